// File: rtl/activation_cache_lookup_ctrl.sv
// Tag/valid store and lookup/refill controller for the 5-way set-associative activation cache.
// Data arrays live outside; this block drives their index, write enables and refill data.
module activation_cache_lookup_ctrl #(
    parameter int unsigned NWAYS      = 5,
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned INDEX_SIZE = 4,
    parameter int unsigned TAG_SIZE   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [TAG_SIZE+INDEX_SIZE-1:0] req_addr,
    input  logic                           flush,
    output logic                           resp_valid,
    output logic                           resp_hit,
    output logic [$clog2(NWAYS)-1:0]       valid_way,
    output logic                           sel_enable,
    output logic [INDEX_SIZE-1:0]          way_index,
    output logic [NWAYS-1:0]               way_we,
    output logic [WORD_SIZE-1:0]           way_wdata,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [TAG_SIZE+INDEX_SIZE-1:0] mem_req_addr,
    input  logic                           mem_rsp_valid,
    input  logic [WORD_SIZE-1:0]           mem_rsp_data
);

    localparam int unsigned AddrW = TAG_SIZE + INDEX_SIZE;
    localparam int unsigned WayW  = $clog2(NWAYS);
    localparam int unsigned NSets = 1 << INDEX_SIZE;

    typedef enum logic [2:0] {
        StIdle, StLookup, StMissReq, StMissWait, StFill, StRespond
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrW-1:0]       addr_q;
    logic [WORD_SIZE-1:0]   data_q;
    logic [WayW-1:0]        way_q;
    logic                   hit_q;
    logic [NSets-1:0]       valid_q [NWAYS];
    logic [WayW-1:0]        rr_q    [NSets];
    logic [TAG_SIZE-1:0]    tag_q   [NWAYS][NSets];

    logic [INDEX_SIZE-1:0]  idx;
    logic [TAG_SIZE-1:0]    tag;
    logic [WayW-1:0]        victim;
    logic                   lookup_hit;
    logic [WayW-1:0]        lookup_way;
    logic                   accept;
    logic                   do_flush;
    logic                   do_fill;
    logic                   capture;

    assign idx          = addr_q[INDEX_SIZE-1:0];
    assign tag          = addr_q[AddrW-1:INDEX_SIZE];
    assign victim       = rr_q[idx];
    assign way_index    = idx;
    assign mem_req_addr = addr_q;
    assign way_wdata    = data_q;

    // Scan downwards so the lowest matching way is the one that sticks.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                lookup_hit = 1'b1;
                lookup_way = WayW'(w);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        valid_way     = '0;
        sel_enable    = 1'b0;
        way_we        = '0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        do_flush      = 1'b0;
        do_fill       = 1'b0;
        capture       = 1'b0;
        case (state_q)
            StIdle: begin
                if (flush) begin
                    do_flush = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept  = 1'b1;
                        state_d = StLookup;
                    end
                end
            end
            StLookup: state_d = lookup_hit ? StRespond : StMissReq;
            StMissReq: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = StMissWait;
            end
            StMissWait: begin
                if (mem_rsp_valid) begin
                    capture = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                do_fill        = 1'b1;
                way_we[victim] = 1'b1;
                state_d        = StRespond;
            end
            StRespond: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                valid_way  = way_q;
                sel_enable = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            valid_q <= '{default: '0};
            rr_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            if (accept) addr_q <= req_addr;
            if (capture) data_q <= mem_rsp_data;
            if (state_q == StLookup) begin
                hit_q <= lookup_hit;
                way_q <= lookup_way;
            end
            if (do_flush) valid_q <= '{default: '0};
            if (do_fill) begin
                valid_q[victim][idx] <= 1'b1;
                rr_q[idx]            <= (victim == WayW'(NWAYS - 1)) ? '0 : victim + 1'b1;
                way_q                <= victim;
            end
        end
    end

    // Tag contents are meaningless until the matching valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (do_fill) tag_q[victim][idx] <= tag;
    end

endmodule

// File: tb/tb_activation_cache_lookup_ctrl.sv
// Directed self-checking bench for activation_cache_lookup_ctrl: misses, hits, round-robin,
// flush priority, memory backpressure and reset during refill.
module tb_activation_cache_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_hit;
    logic [2:0]  valid_way;
    logic        sel_enable;
    logic [3:0]  way_index;
    logic [4:0]  way_we;
    logic [15:0] way_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [11:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    always #5 clk = ~clk;

    activation_cache_lookup_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_hit      (resp_hit),
        .valid_way     (valid_way),
        .sel_enable    (sel_enable),
        .way_index     (way_index),
        .way_we        (way_we),
        .way_wdata     (way_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({name, "_resp_hit"}, 32'(resp_hit), 32'd0);
        chk({name, "_valid_way"}, 32'(valid_way), 32'd0);
        chk({name, "_sel_enable"}, 32'(sel_enable), 32'd0);
        chk({name, "_way_we"}, 32'(way_we), 32'd0);
        chk({name, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({name, "_way_index"}, 32'(way_index), 32'd0);
        chk({name, "_way_wdata"}, 32'(way_wdata), 32'd0);
        chk({name, "_mem_req_addr"}, 32'(mem_req_addr), 32'd0);
    endtask

    // Present one request; on return the DUT sits in the cycle after acceptance.
    task automatic send_req(input logic [11:0] addr);
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        t0        = cyc - 1;
    endtask

    // rd = cycles mem_req_ready is held low, n = cycles from acceptance to refill data.
    task automatic lookup(input logic [11:0] addr, input bit exp_hit, input int exp_way,
                          input int rd, input int n, input logic [15:0] data);
        send_req(addr);
        chk("lookup_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("lookup_resp_valid", 32'(resp_valid), 32'd0);
        step();
        if (!exp_hit) begin
            chk("missreq_valid", 32'(mem_req_valid), 32'd1);
            chk("missreq_addr", 32'(mem_req_addr), 32'(addr));
            chk("missreq_sel_enable", 32'(sel_enable), 32'd0);
            for (int i = 0; i < rd; i++) begin
                step();
                chk("bp_mem_req_valid", 32'(mem_req_valid), 32'd1);
                chk("bp_mem_req_addr", 32'(mem_req_addr), 32'(addr));
                chk("bp_sel_enable", 32'(sel_enable), 32'd0);
            end
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            chk("wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
            for (int i = 0; i < n - 1; i++) begin
                chk("wait_sel_enable", 32'(sel_enable), 32'd0);
                step();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = data;
            step();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 16'h0;
            chk("fill_way_we", 32'(way_we), 32'd1 << exp_way);
            chk("fill_way_index", 32'(way_index), 32'(addr[3:0]));
            chk("fill_way_wdata", 32'(way_wdata), 32'(data));
            chk("fill_resp_valid", 32'(resp_valid), 32'd0);
            step();
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_hit", 32'(resp_hit), 32'(exp_hit));
        chk("resp_valid_way", 32'(valid_way), 32'(exp_way));
        chk("resp_sel_enable", 32'(sel_enable), 32'd1);
        chk("resp_way_we", 32'(way_we), 32'd0);
        chk("resp_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("resp_latency", 32'(cyc - t0), exp_hit ? 32'd2 : 32'(4 + rd + n));
        step();
        chk("post_resp_sel_enable", 32'(sel_enable), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = 12'h0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 16'h0;
        repeat (3) step();
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Cold miss, data two cycles after acceptance, then hit.
        lookup(12'h3A5, 1'b0, 0, 0, 2, 16'h1234);
        lookup(12'h3A5, 1'b1, 0, 0, 1, 16'h0);

        // Memory holds off the request for 4 cycles.
        lookup(12'h7C2, 1'b0, 0, 4, 1, 16'hBEEF);

        // Flush wins over a same-cycle request.
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 12'h3A5;
        #1;
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("flush_not_accepted", 32'(req_ready), 32'd1);
        chk("flush_no_mem", 32'(mem_req_valid), 32'd0);
        // Pointer for set 5 still advanced past way 0; flush does not touch it.
        lookup(12'h3A5, 1'b0, 1, 0, 3, 16'h5678);
        lookup(12'h7C2, 1'b0, 1, 0, 1, 16'hBEF0);

        // Reset while waiting for refill data.
        send_req(12'h159);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        step();
        chk_idle_outputs("midreset_held");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        lookup(12'h159, 1'b0, 0, 0, 1, 16'h0159);

        // Round-robin over set 5 from a fresh pointer.
        for (int t = 1; t <= 6; t++) begin
            lookup({8'(t), 4'h5}, 1'b0, (t - 1) % 5, 0, 1, 16'h1000 + 16'(t));
        end
        for (int t = 2; t <= 6; t++) begin
            lookup({8'(t), 4'h5}, 1'b1, (t - 1) % 5, 0, 1, 16'h0);
        end
        // Tag 0x01 was evicted by tag 0x06; hits left the pointer at way 1.
        lookup(12'h015, 1'b0, 1, 0, 2, 16'h2001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
